// File: rtl/svf_pkg.sv
// Shared codes and constants for the multi-mode state variable filter.
package svf_pkg;

    // Output response selected at sample accept
    localparam logic [1:0] MODE_LP    = 2'd0;
    localparam logic [1:0] MODE_BP    = 2'd1;
    localparam logic [1:0] MODE_HP    = 2'd2;
    localparam logic [1:0] MODE_NOTCH = 2'd3;

    // Coefficient shadow-register select
    localparam logic [1:0] SEL_A1 = 2'd0;
    localparam logic [1:0] SEL_A2 = 2'd1;
    localparam logic [1:0] SEL_A3 = 2'd2;
    localparam logic [1:0] SEL_K  = 2'd3;

    // Per-sample sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StMul,
        StUpd
    } svf_state_e;

    // Products per sample through the shared multiplier
    localparam int unsigned NUM_STEPS = 5;
    localparam int unsigned STEP_W    = 3;

endpackage

// File: rtl/svf_sat_trunc.sv
// Signed saturating narrower: clamps an IN_W-bit two's complement value to OUT_W bits.
module svf_sat_trunc #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    logic [IN_W-OUT_W:0] w_top;
    logic                w_fits;

    // Value fits when every bit above the target sign bit matches it
    assign w_top  = i_data[IN_W-1:OUT_W-1];
    assign w_fits = (&w_top) | ~(|w_top);

    // Pass through, or clamp toward the sign of the input
    always_comb begin
        if (w_fits) begin
            o_data = i_data[OUT_W-1:0];
        end else if (i_data[IN_W-1]) begin
            o_data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            o_data = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/state_variable_filter_mm.sv
// Multi-mode trapezoidal state variable filter, one shared multiplier, 8-cycle sample period.
module state_variable_filter_mm
    import svf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC   = 14,
    parameter int ST_W   = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_mode,
    input  logic              i_flush,
    input  logic              i_coef_we,
    input  logic [1:0]        i_coef_sel,
    input  logic [COEF_W-1:0] i_coef,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    localparam int PROD_W = ST_W + COEF_W;
    localparam int ACC_W  = PROD_W + 2;

    svf_state_e r_state, w_state_next;
    logic [STEP_W-1:0] r_step;
    logic [DATA_W-1:0] r_v0;
    logic [1:0]        r_mode;
    logic              r_flush_pend;
    logic signed [ST_W-1:0]   r_ic1, r_ic2, r_v1, r_v2, r_v3;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PROD_W-1:0] r_kv1;
    logic [COEF_W-1:0] r_sh_a1, r_sh_a2, r_sh_a3, r_sh_k;
    logic [COEF_W-1:0] r_a1, r_a2, r_a3, r_k;
    logic [DATA_W-1:0] r_o_data;
    logic              r_o_valid;

    logic                     w_accept;
    logic signed [ST_W-1:0]   w_mul_a;
    logic signed [COEF_W-1:0] w_mul_b;
    logic signed [PROD_W-1:0] w_mul_a_x, w_mul_b_x, w_prod, w_prod_sh;
    logic signed [ACC_W-1:0]  w_add_a, w_sum, w_out_wide;
    logic [ST_W-1:0]          w_sum_sat, w_v3_sat, w_ic1_sat, w_ic2_sat;
    logic signed [ST_W:0]     w_v3_wide;
    logic signed [ST_W+1:0]   w_ic1_wide, w_ic2_wide;
    logic [DATA_W-1:0]        w_out_sat;

    assign w_accept = (r_state == StIdle) && i_valid;
    assign o_data   = r_o_data;
    assign o_valid  = r_o_valid;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake output
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_ready = 1'b1;
                if (i_valid) w_state_next = StSub;
            end
            StSub: w_state_next = StMul;
            StMul: if (r_step == STEP_W'(NUM_STEPS - 1)) w_state_next = StUpd;
            StUpd: w_state_next = StIdle;
        endcase
    end

    // Operand routing for the shared multiplier and its accumulate adder
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        w_add_a = '0;
        if (r_state == StMul) begin
            case (r_step)
                3'd0: begin w_mul_a = r_ic1; w_mul_b = r_a1; end
                3'd1: begin w_mul_a = r_v3;  w_mul_b = r_a2; w_add_a = r_acc; end
                3'd2: begin
                    w_mul_a = r_ic1;
                    w_mul_b = r_a2;
                    w_add_a = {{(ACC_W-ST_W){r_ic2[ST_W-1]}}, r_ic2};
                end
                3'd3: begin w_mul_a = r_v3;  w_mul_b = r_a3; w_add_a = r_acc; end
                3'd4: begin w_mul_a = r_v1;  w_mul_b = r_k;  end
                default: ;
            endcase
        end
    end

    assign w_mul_a_x = {{(PROD_W-ST_W){w_mul_a[ST_W-1]}}, w_mul_a};
    assign w_mul_b_x = {{(PROD_W-COEF_W){w_mul_b[COEF_W-1]}}, w_mul_b};
    assign w_prod    = w_mul_a_x * w_mul_b_x;
    assign w_prod_sh = w_prod >>> FRAC;
    assign w_sum     = w_add_a + {{(ACC_W-PROD_W){w_prod_sh[PROD_W-1]}}, w_prod_sh};

    assign w_v3_wide  = {{(ST_W+1-DATA_W){r_v0[DATA_W-1]}}, r_v0} - {r_ic2[ST_W-1], r_ic2};
    assign w_ic1_wide = {r_v1[ST_W-1], r_v1, 1'b0} - {{2{r_ic1[ST_W-1]}}, r_ic1};
    assign w_ic2_wide = {r_v2[ST_W-1], r_v2, 1'b0} - {{2{r_ic2[ST_W-1]}}, r_ic2};

    // Response select at full width before the output clamp
    always_comb begin
        w_out_wide = '0;
        unique case (r_mode)
            MODE_LP: w_out_wide = {{(ACC_W-ST_W){r_v2[ST_W-1]}}, r_v2};
            MODE_BP: w_out_wide = {{(ACC_W-ST_W){r_v1[ST_W-1]}}, r_v1};
            MODE_HP: w_out_wide = {{(ACC_W-DATA_W){r_v0[DATA_W-1]}}, r_v0}
                                - {{(ACC_W-PROD_W){r_kv1[PROD_W-1]}}, r_kv1}
                                - {{(ACC_W-ST_W){r_v2[ST_W-1]}}, r_v2};
            MODE_NOTCH: w_out_wide = {{(ACC_W-DATA_W){r_v0[DATA_W-1]}}, r_v0}
                                   - {{(ACC_W-PROD_W){r_kv1[PROD_W-1]}}, r_kv1};
        endcase
    end

    svf_sat_trunc #(.IN_W(ACC_W), .OUT_W(ST_W)) u_sat_sum (
        .i_data(w_sum), .o_data(w_sum_sat)
    );
    svf_sat_trunc #(.IN_W(ST_W + 1), .OUT_W(ST_W)) u_sat_v3 (
        .i_data(w_v3_wide), .o_data(w_v3_sat)
    );
    svf_sat_trunc #(.IN_W(ST_W + 2), .OUT_W(ST_W)) u_sat_ic1 (
        .i_data(w_ic1_wide), .o_data(w_ic1_sat)
    );
    svf_sat_trunc #(.IN_W(ST_W + 2), .OUT_W(ST_W)) u_sat_ic2 (
        .i_data(w_ic2_wide), .o_data(w_ic2_sat)
    );
    svf_sat_trunc #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_out (
        .i_data(w_out_wide), .o_data(w_out_sat)
    );

    // Datapath: coefficient shadows, per-step state updates and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step       <= '0;
            r_v0         <= '0;
            r_mode       <= MODE_LP;
            r_flush_pend <= 1'b0;
            r_ic1        <= '0;
            r_ic2        <= '0;
            r_v1         <= '0;
            r_v2         <= '0;
            r_v3         <= '0;
            r_acc        <= '0;
            r_kv1        <= '0;
            r_sh_a1      <= '0;
            r_sh_a2      <= '0;
            r_sh_a3      <= '0;
            r_sh_k       <= '0;
            r_a1         <= '0;
            r_a2         <= '0;
            r_a3         <= '0;
            r_k          <= '0;
            r_o_data     <= '0;
            r_o_valid    <= 1'b0;
        end else begin
            r_o_valid <= 1'b0;
            if (i_coef_we) begin
                unique case (i_coef_sel)
                    SEL_A1: r_sh_a1 <= i_coef;
                    SEL_A2: r_sh_a2 <= i_coef;
                    SEL_A3: r_sh_a3 <= i_coef;
                    SEL_K:  r_sh_k  <= i_coef;
                endcase
            end
            unique case (r_state)
                StIdle: begin
                    // Flush lands on the accept edge too, so the new sample sees zero state
                    if (i_flush) begin
                        r_ic1 <= '0;
                        r_ic2 <= '0;
                    end
                    if (w_accept) begin
                        r_v0   <= i_data;
                        r_mode <= i_mode;
                        r_a1   <= r_sh_a1;
                        r_a2   <= r_sh_a2;
                        r_a3   <= r_sh_a3;
                        r_k    <= r_sh_k;
                    end
                end
                StSub: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    r_v3   <= w_v3_sat;
                    r_step <= '0;
                end
                StMul: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    r_step <= r_step + 3'd1;
                    case (r_step)
                        3'd0, 3'd2: r_acc <= w_sum;
                        3'd1:       r_v1  <= w_sum_sat;
                        3'd3:       r_v2  <= w_sum_sat;
                        3'd4:       r_kv1 <= w_prod_sh;
                        default: ;
                    endcase
                end
                StUpd: begin
                    if (r_flush_pend || i_flush) begin
                        r_ic1 <= '0;
                        r_ic2 <= '0;
                    end else begin
                        r_ic1 <= w_ic1_sat;
                        r_ic2 <= w_ic2_sat;
                    end
                    r_flush_pend <= 1'b0;
                    r_o_data     <= w_out_sat;
                    r_o_valid    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/state_variable_filter_mm.md
# state_variable_filter_mm

Multi-mode, parametrised state variable filter: the successor to the lowpass-only SVF in the synth voice path. It implements the trapezoidal-integrator SVF (Simper linear trap, optimised form) with runtime-selectable lowpass/bandpass/highpass/notch output. All products go through one shared multiplier under a per-sample FSM. Coefficients (a1, a2, a3, k) are loaded through a shadow-register port by the cutoff/LUT logic upstream. The block sits between the oscillator/mixer and the output stage, and uses a valid/ready input and a valid-pulse output.

## Interface
- DATA_W, 16, signed sample width (in and out)
- COEF_W, 18, signed coefficient width
- FRAC, 14, coefficient fractional bits (Q(COEF_W-FRAC).FRAC; default range ±8)
- ST_W, DATA_W+2, signed width of v1/v2/v3/ic1eq/ic2eq
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_data  in  DATA_W  input sample v0, signed
- i_valid  in  1  i_data valid
- o_ready  out  1  block can accept a sample (high only in IDLE)
- i_mode  in  2  0 LP, 1 BP, 2 HP, 3 notch; sampled at accept
- i_flush  in  1  zero the integrator states (ic1eq, ic2eq)
- i_coef_we  in  1  coefficient write strobe
- i_coef_sel  in  2  0 a1, 1 a2, 2 a3, 3 k
- i_coef  in  COEF_W  coefficient value, signed
- o_data  out  DATA_W  filtered sample, saturated
- o_valid  out  1  one-cycle pulse, o_data valid

## Operation
- States: IDLE, SUB, MUL, UPD.
- IDLE: o_ready=1. On i_valid&&o_ready the block captures i_data and i_mode, and copies the shadow coefficients to the active coefficients. Next state is SUB.
- SUB: v3 = v0 − ic2eq. Next state is MUL with step counter 0.
- MUL runs steps 0–4, one product per cycle, product = (a·b) >>> FRAC (arithmetic shift, truncation):
  - step 0: a1·ic1eq
  - step 1: a2·v3, so v1 = step0 + step1
  - step 2: a2·ic1eq
  - step 3: a3·v3, so v2 = ic2eq + step2 + step3
  - step 4: k·v1
- UPD:
  - ic1eq = 2·v1 − ic1eq and ic2eq = 2·v2 − ic2eq.
  - Output select: LP = v2, BP = v1, HP = v0 − k·v1 − v2, notch = v0 − k·v1.
  - o_data = sat_DATA_W(selected), o_valid=1. Next state is IDLE.
- Width rules:
  - All state sums are saturated to ST_W.
  - Products are computed at full width ST_W+COEF_W before the shift.
  - The output saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Coefficient writes are accepted on any cycle and go to the shadow registers. They never affect a sample in flight.
- Coefficient boundary cases:
  - A write on the accept cycle is not used for that sample; it applies from the next accept.
  - Multiple writes to the same sel before an accept: the last one wins.
- i_flush in IDLE zeroes ic1eq and ic2eq on the next edge.
- i_flush during SUB, MUL or UPD:
  - It is latched.
  - The current sample completes with the old states and its output is produced normally.
  - At UPD the states are written to 0 instead of the update.
- i_flush on the same cycle as an accept: the flush applies first, so the sample sees ic1eq = ic2eq = 0.
- Reset values:
  - o_data=0, o_valid=0, o_ready=1 (IDLE).
  - All states and v-registers are 0.
  - Active and shadow coefficients are all 0; the reset output is therefore 0 for any input.

## Timing
- Accept at cycle T (edge where i_valid&&o_ready).
- SUB at T+1, MUL at T+2..T+6, UPD at T+7.
- o_valid=1 and o_data valid during cycle T+8. o_ready is also high from T+8.
- Latency is 8 cycles and throughput is 1 sample per 8 cycles. A back-to-back accept is possible at T+8.
- o_data holds its value until the next UPD. o_valid is low outside that single cycle.
- i_valid while o_ready=0 is ignored. The upstream holds i_data until accepted.
- rst during any state: on the next edge the FSM returns to IDLE and all registers take their reset values; the in-flight sample is dropped with no o_valid.

## Structure
- Package svf_pkg holds:
  - the mode codes (MODE_LP/BP/HP/NOTCH)
  - the coefficient select codes (SEL_A1/A2/A3/K)
  - the FSM state encoding
  - the step count (5)
- Sub-module svf_sat_trunc: parametrised in-width/out-width signed saturator. It is used for ST_W state clamping and DATA_W output clamping.
- The single shared multiplier and the FSM live in the top module.

## Test plan
- Reset, then coefficients a1=a2=a3=4096 (0.25) and k=32768 (2.0), mode LP. Input 1000 then 0 → o_data 250 then 500; each o_valid exactly 8 cycles after its accept.
- Same coefficients, single sample 1000 from zero state:
  - BP → 250
  - HP → 250
  - notch → 500
- Shadow coefficients: write a1=0 on the accept cycle of sample 1 → sample 1 still uses 0.25. Sample 2 uses 0. Check v1 via the BP output.
- Flush: i_flush pulsed during MUL of the second sample of the impulse test → that sample's output is still 500. The next input 0 gives 0.
- Saturation: a1=a2=a3=114688 (7.0), input 32767 repeatedly → o_data clamps at 32767 with no wrap. Repeat with −32768 → clamps at −32768.
- Handshake and reset: i_valid held high continuously → accepts exactly every 8 cycles. rst asserted at T+4 → no o_valid, o_ready=1 next cycle, and the next sample's output equals the fresh-state result.
